// File: rtl/sa_cdc_req_tx.sv
// rtl/sa_cdc_req_tx.sv - source side of a 4-phase req/ack bundled-data CDC (optional timeout: SA_CDC_REQ_TX_TIMEOUT_EN)
module sa_cdc_req_tx #(
  parameter int DW              = 32,
  parameter int ACK_SYNC_STAGES = 3,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          src_valid,
  output logic          src_ready,
  input  logic [DW-1:0] src_data,
  output logic          cdc_req,
  output logic [DW-1:0] cdc_data,
  input  logic          cdc_ack,
  output logic          busy,
  output logic          done,
  output logic          err_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic                       req_q, req_d;
  logic [DW-1:0]              data_q, data_d;
  logic                       done_q, done_d;
  logic [ACK_SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic                       ack_s;

  // Shift chain for the asynchronous ack; only the last stage is ever used.
  always_comb begin
    ack_sync_d = {ack_sync_q[ACK_SYNC_STAGES-2:0], cdc_ack};
    ack_s      = ack_sync_q[ACK_SYNC_STAGES-1];
  end

  // Ready depends on registers only, never on src_valid; a stale high ack blocks new requests.
  always_comb begin
    src_ready = (state_q == IDLE) && !ack_s;
  end

  // Handshake sequencing: IDLE -> REQ (wait ack high) -> DROP (wait ack low) -> IDLE.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (src_valid && src_ready) begin
          data_d  = src_data;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = DROP;
        end
      end
      DROP: begin
        // A spurious ack rise here is ignored; only a low ack completes the cycle.
        if (!ack_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, request, bundled data, done pulse and ack synchronizer registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      ack_sync_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      data_q     <= data_d;
      done_q     <= done_d;
      ack_sync_q <= ack_sync_d;
    end
  end

  assign cdc_req  = req_q;
  assign cdc_data = data_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE);

`ifdef SA_CDC_REQ_TX_TIMEOUT_EN
  localparam int             CW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  TO_CNT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // Phase timer: restarts on any state change, counts cycles in REQ/DROP, saturates; flag is sticky.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q != IDLE) && (cnt_q != TO_CNT)) begin
      cnt_d = cnt_q + CW'(1);
    end
    if (cnt_d == TO_CNT) begin
      err_d = 1'b1;
    end
  end

  // Timeout counter and sticky error flag registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sa_cdc_req_tx.sv
// tb/tb_sa_cdc_req_tx.sv - directed self-checking bench for sa_cdc_req_tx
module tb_sa_cdc_req_tx;

  localparam int DW = 32;
`ifdef SA_CDC_REQ_TX_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          src_valid;
  logic          src_ready;
  logic [DW-1:0] src_data;
  logic          cdc_req;
  logic [DW-1:0] cdc_data;
  logic          cdc_ack;
  logic          busy;
  logic          done;
  logic          err_timeout;

  logic dir_ack  = 1'b0;
  logic resp_ack = 1'b0;
  logic resp_en  = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  int            done_count = 0;
  int            rise_count = 0;
  int            data_err   = 0;
  logic          prev_req   = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  logic [DW-1:0] rx_q[$];

  assign cdc_ack = resp_en ? resp_ack : dir_ack;

  always #5 clk = ~clk;

  sa_cdc_req_tx #(
    .DW              (DW),
    .ACK_SYNC_STAGES (3),
    .TIMEOUT_CYCLES  (8)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .src_data    (src_data),
    .cdc_req     (cdc_req),
    .cdc_data    (cdc_data),
    .cdc_ack     (cdc_ack),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout)
  );

  // Destination-side observer: records words on req rise, counts done pulses, flags data moving under req.
  always @(negedge clk) begin
    if (done === 1'b1) done_count <= done_count + 1;
    if (cdc_req === 1'b1 && prev_req === 1'b0) begin
      rise_count <= rise_count + 1;
      rx_q.push_back(cdc_data);
    end
    if (cdc_req === 1'b1 && prev_req === 1'b1 && cdc_data !== prev_data) data_err <= data_err + 1;
    prev_req  <= cdc_req;
    prev_data <= cdc_data;
  end

  // Random-latency responder (1..20 cycles per ack edge).
  always begin
    int d;
    @(negedge clk);
    if (resp_en && cdc_req === 1'b1 && !resp_ack) begin
      d = $urandom_range(1, 20);
      repeat (d - 1) @(negedge clk);
      resp_ack = 1'b1;
    end else if (resp_en && cdc_req === 1'b0 && resp_ack) begin
      d = $urandom_range(1, 20);
      repeat (d - 1) @(negedge clk);
      resp_ack = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_req(input logic val, input int max, input string tag);
    int n = 0;
    while (cdc_req !== val && n < max) begin
      tick(1);
      n++;
    end
    check_eq(tag, {31'd0, cdc_req}, {31'd0, val});
  endtask

  task automatic wait_done(input int max, input string tag);
    int n = 0;
    while (done !== 1'b1 && n < max) begin
      tick(1);
      n++;
    end
    check_eq(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic finish_hs(input string tag);
    dir_ack = 1'b1;
    wait_req(1'b0, 20, {tag, "_fall"});
    dir_ack = 1'b0;
    wait_done(20, {tag, "_done"});
  endtask

  initial begin
    int snap_rise;
    int done0;
    int n;
    int stall;

    rstn      = 1'b0;
    src_valid = 1'b0;
    src_data  = '0;

    // Reset
    tick(3);
    check_eq("rst_req",   {31'd0, cdc_req}, 32'd0);
    check_eq("rst_data",  cdc_data, 32'd0);
    check_eq("rst_busy",  {31'd0, busy}, 32'd0);
    check_eq("rst_done",  {31'd0, done}, 32'd0);
    check_eq("rst_err",   {31'd0, err_timeout}, 32'd0);
    rstn = 1'b1;
    tick(1);
    check_eq("rst_ready", {31'd0, src_ready}, 32'd1);

    // Single transfer with held backpressure word
    src_valid = 1'b1;
    src_data  = 32'hDEADBEEF;
    tick(1);
    check_eq("req_rise",  {31'd0, cdc_req}, 32'd1);
    check_eq("req_data",  cdc_data, 32'hDEADBEEF);
    check_eq("req_busy",  {31'd0, busy}, 32'd1);
    src_data = 32'h12345678;
    tick(1);
    dir_ack = 1'b1;
    tick(3);
    check_eq("req_hold",  {31'd0, cdc_req}, 32'd1);
    check_eq("bp_ready1", {31'd0, src_ready}, 32'd0);
    tick(1);
    check_eq("req_fall",  {31'd0, cdc_req}, 32'd0);
    check_eq("drop_data", cdc_data, 32'hDEADBEEF);
    tick(2);
    dir_ack = 1'b0;
    tick(3);
    check_eq("done_early", {31'd0, done}, 32'd0);
    check_eq("bp_ready2",  {31'd0, src_ready}, 32'd0);
    tick(1);
    check_eq("done_pulse", {31'd0, done}, 32'd1);
    check_eq("done_ready", {31'd0, src_ready}, 32'd1);
    check_eq("done_data",  cdc_data, 32'hDEADBEEF);
    tick(1);
    check_eq("done_clear", {31'd0, done}, 32'd0);
    check_eq("bp_req",     {31'd0, cdc_req}, 32'd1);
    check_eq("bp_data",    cdc_data, 32'h12345678);
    src_valid = 1'b0;

    // Stale ack: reset mid-REQ while ack is high
    dir_ack = 1'b1;
    tick(2);
    rstn = 1'b0;
    tick(1);
    check_eq("mid_rst_req",  {31'd0, cdc_req}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    tick(2);
    rstn      = 1'b1;
    snap_rise = rise_count;
    tick(3);
    check_eq("stale_ready", {31'd0, src_ready}, 32'd0);
    src_valid = 1'b1;
    src_data  = 32'hCAFEF00D;
    tick(4);
    check_eq("stale_noreq",  {31'd0, cdc_req}, 32'd0);
    check_eq("stale_ready2", {31'd0, src_ready}, 32'd0);
    dir_ack = 1'b0;
    tick(2);
    check_eq("stale_hold", {31'd0, src_ready}, 32'd0);
    tick(1);
    check_eq("stale_release", {31'd0, src_ready}, 32'd1);
    check_eq("stale_noedge",  rise_count, snap_rise);
    tick(1);
    check_eq("stale_req",  {31'd0, cdc_req}, 32'd1);
    check_eq("stale_data", cdc_data, 32'hCAFEF00D);
    src_valid = 1'b0;
    finish_hs("stale_hs");
    tick(1);

    // Stream of 16 words against the random responder
    rx_q.delete();
    done0   = done_count;
    stall   = 0;
    resp_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      src_data  = i;
      src_valid = 1'b1;
      n = 0;
      while (src_ready !== 1'b1 && n < 200) begin
        tick(1);
        n++;
      end
      if (n >= 200) stall++;
      tick(1);
      src_valid = 1'b0;
    end
    n = 0;
    while (done_count < done0 + 16 && n < 2000) begin
      tick(1);
      n++;
    end
    tick(1);
    check_eq("stream_stall", stall, 32'd0);
    check_eq("stream_done",  done_count - done0, 32'd16);
    check_eq("stream_count", rx_q.size(), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < rx_q.size()) check_eq($sformatf("stream_word%0d", i), rx_q[i], i);
    end
    check_eq("data_stable", data_err, 32'd0);
    resp_en = 1'b0;

    // Never-acked request: timeout behaviour
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick(1);
    src_valid = 1'b1;
    src_data  = 32'h0BADF00D;
    tick(1);
    src_valid = 1'b0;
    check_eq("to_req", {31'd0, cdc_req}, 32'd1);
    tick(7);
    check_eq("to_early", {31'd0, err_timeout}, 32'd0);
    tick(1);
    check_eq("to_set", {31'd0, err_timeout}, {31'd0, TO_EN});
    tick(10);
    check_eq("to_sticky",   {31'd0, err_timeout}, {31'd0, TO_EN});
    check_eq("to_req_hold", {31'd0, cdc_req}, 32'd1);
    check_eq("to_busy",     {31'd0, busy}, 32'd1);
    rstn = 1'b0;
    tick(2);
    check_eq("to_rst_err", {31'd0, err_timeout}, 32'd0);
    rstn = 1'b1;
    tick(1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
